// File: rtl/sram_ctrl_pkg.sv
// Shared widths and the response record for the SRAM request controller.
package sram_ctrl_pkg;
    localparam int SRAM_AW = 14;
    localparam int SRAM_DW = 32;
    localparam int SRAM_BE = 4;

    typedef struct packed {
        logic [SRAM_DW-1:0] data;
        logic               err;
    } sram_rsp_t;
endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request (valid/ready) and read-response (valid/ready) channels of sram_req_ctrl.
interface sram_req_ctrl_if;
    logic                              req_valid;
    logic                              req_ready;
    logic                              req_we;
    logic [15:0]                       req_addr;
    logic [sram_ctrl_pkg::SRAM_DW-1:0] req_wdata;
    logic [sram_ctrl_pkg::SRAM_BE-1:0] req_wstrb;
    logic                              rvalid;
    logic                              rready;
    logic [sram_ctrl_pkg::SRAM_DW-1:0] rdata;
    logic                              rerr;
    logic                              wr_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rready,
        input  req_ready, rvalid, rdata, rerr, wr_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rready,
        output req_ready, rvalid, rdata, rerr, wr_err
    );
endinterface

// File: rtl/sram_rsp_fifo.sv
// Small response FIFO; pointers wrap modulo DEPTH so non-power-of-two depths work.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = sram_rsp_t,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count
);
    T               mem [DEPTH];
    logic [PW-1:0]  wptr, rptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= nxt(wptr);
            end
            if (pop) rptr <= nxt(rptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[rptr];

    // Upstream ready logic reserves a slot for every in-flight read.
    a_no_push_full: assert property (@(posedge CK) disable iff (RST)
        !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/sram_req_ctrl.sv
// Issues word requests to the 16K x 32 SRAM wrapper and returns read data via a FIFO.
// Optional misaligned-access error reporting: define SRAM_REQ_CTRL_ERR_EN.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic               CK,
    input  logic               RST,
    sram_req_ctrl_if.slave     bus,
    output logic               CS,
    output logic               OE,
    output logic [SRAM_BE-1:0] WEB,
    output logic [SRAM_AW-1:0] A,
    output logic [SRAM_DW-1:0] DI,
    input  logic [SRAM_DW-1:0] DO
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          acc, issue, rd_pend, pop, mis, rd_err;
    logic [CW-1:0] count;
    logic [3:0]    occ;
    sram_rsp_t     din, head;

    // Occupancy seen by a new request: entries held, plus the read in flight, minus this pop.
    assign pop           = bus.rvalid && bus.rready;
    assign occ           = 4'(count) + 4'(rd_pend) - 4'(pop);
    assign bus.req_ready = occ < 4'(RSP_DEPTH);
    assign acc           = bus.req_valid && bus.req_ready && !RST;

`ifdef SRAM_REQ_CTRL_ERR_EN
    logic wr_err_q;
    assign mis = |bus.req_addr[1:0];

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            rd_err   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rd_err   <= acc && !bus.req_we && mis;
            wr_err_q <= acc && bus.req_we && mis;
        end
    end

    assign bus.wr_err = wr_err_q;
    assign bus.rerr   = head.err;
`else
    logic unused_bits;
    assign mis         = 1'b0;
    assign rd_err      = 1'b0;
    assign unused_bits = ^{bus.req_addr[1:0], head.err};
    assign bus.wr_err  = 1'b0;
    assign bus.rerr    = 1'b0;
`endif

    assign issue = acc && !mis;

    always_comb begin
        CS  = 1'b0;
        WEB = '1;
        A   = '0;
        DI  = '0;
        if (issue) begin
            CS = 1'b1;
            A  = bus.req_addr[15:2];
            if (bus.req_we) begin
                WEB = ~bus.req_wstrb;
                DI  = bus.req_wdata;
            end
        end
    end

    // Misaligned reads ride the same one-cycle slot so ordering and latency hold.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) rd_pend <= 1'b0;
        else     rd_pend <= acc && !bus.req_we;
    end

    assign OE  = rd_pend && !rd_err;
    assign din = rd_err ? '{data: '0, err: 1'b1} : '{data: DO, err: 1'b0};

    sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .T(sram_rsp_t)) u_fifo (
        .CK   (CK),
        .RST  (RST),
        .push (rd_pend),
        .din  (din),
        .pop  (pop),
        .head (head),
        .count(count)
    );

    assign bus.rvalid = (count != '0);
    assign bus.rdata  = head.data;
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomized self-checking bench for sram_req_ctrl against a queue/array reference model.
module tb_sram_req_ctrl;
    localparam int D = 2;

    logic        CK = 1'b0;
    logic        RST;
    logic        CS, OE;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI, DO;

    sram_req_ctrl_if bus ();

    sram_req_ctrl #(.RSP_DEPTH(D)) dut (
        .CK(CK), .RST(RST), .bus(bus),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 CK = ~CK;

    // Behavioural SRAM wrapper: registered read, byte-masked write, DO gated by OE.
    logic [31:0] sram [0:16383];
    logic [31:0] sram_q;
    always @(posedge CK) begin
        if (CS) begin
            if (WEB != 4'hF) begin
                for (int b = 0; b < 4; b++)
                    if (!WEB[b]) sram[A][b*8 +: 8] <= DI[b*8 +: 8];
            end else begin
                sram_q <= sram[A];
            end
        end
    end
    assign DO = OE ? sram_q : 32'hBAD0_BAD0;

    typedef struct packed {
        logic        req_ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rerr;
        logic        wr_err;
        logic        cs;
        logic        oe;
        logic [3:0]  web;
        logic [13:0] a;
        logic [31:0] di;
    } pins_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exq [$];
    logic [31:0] ref_mem [int];
    int          wlist [$];
    int          cyc = 0;
    logic        rdp_m = 1'b0, wre_m = 1'b0;
    int          checks = 0, failures = 0;

    // Drive one cycle, return observed pins and what the reference model predicts.
    task automatic step(input logic v, input logic we, input logic [15:0] ad,
                        input logic [31:0] wd, input logic [3:0] ws, input logic rr,
                        output pins_t o, output pins_t e);
        logic        mis, pop, acc;
        int          w;
        logic [31:0] m;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = ad;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        bus.rready    = rr;
        @(negedge CK);
`ifdef SRAM_REQ_CTRL_ERR_EN
        mis = (ad[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        w = int'(ad[15:2]);
        e = '0;
        e.rvalid = (exq.size() != 0) && (exq[0].cyc + 2 <= cyc);
        if (e.rvalid) begin
            e.rdata = exq[0].data;
            e.rerr  = exq[0].err;
        end
        pop         = e.rvalid && rr;
        e.req_ready = (exq.size() - int'(pop)) < D;
        acc         = v && e.req_ready;
        e.oe        = rdp_m;
        e.wr_err    = wre_m;
        e.web       = 4'hF;
        if (acc && !mis) begin
            e.cs = 1'b1;
            e.a  = ad[15:2];
            if (we) begin
                e.web = ~ws;
                e.di  = wd;
            end
        end
        o = '{bus.req_ready, bus.rvalid, bus.rdata, bus.rerr, bus.wr_err, CS, OE, WEB, A, DI};
        if (!o.rvalid) begin
            o.rdata = '0;
            o.rerr  = 1'b0;
        end
        if (pop) exq.delete(0);
        rdp_m = acc && !we && !mis;
        wre_m = acc && we && mis;
        if (acc && !we)
            exq.push_back('{data: (mis || !ref_mem.exists(w)) ? 32'h0 : ref_mem[w], err: mis, cyc: cyc});
        if (acc && we && !mis) begin
            if (ref_mem.exists(w)) m = ref_mem[w];
            else begin
                m = 32'h0;
                wlist.push_back(w);
            end
            for (int b = 0; b < 4; b++) if (ws[b]) m[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[w] = m;
        end
        @(posedge CK);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        pins_t o, e;
        RST = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0; bus.rready = 1'b0;
        @(negedge CK);
        o = '{bus.req_ready, bus.rvalid, bus.rdata, bus.rerr, bus.wr_err, CS, OE, WEB, A, DI};
        e = '0; e.req_ready = 1'b1; e.web = 4'hF;
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset got=%h exp=%h", o, e); end
        @(posedge CK); #1;
        RST = 1'b0;
    endtask

    task automatic test_prefill();
        pins_t o, e;
        for (int i = 0; i < 32; i++) begin
            int w;
            w = (i < 16) ? i : int'($urandom_range(16, 16383));
            step(1'b1, 1'b1, {w[13:0], 2'b00}, $urandom, 4'hF, 1'b1, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL prefill cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    task automatic test_write_read();
        pins_t o, e;
        step(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL wr_rd_w got=%h exp=%h", o, e); end
        step(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o.cs !== 1'b1 || o.a !== 14'h4 || o.web !== 4'hF) begin
            failures++; $display("FAIL wr_rd_issue got cs=%b a=%h web=%h exp cs=1 a=4 web=f", o.cs, o.a, o.web);
        end
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL wr_rd_pend got=%h exp=%h", o, e); end
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o.rvalid !== 1'b1 || o.rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_rd_data got rvalid=%b rdata=%h exp rvalid=1 rdata=deadbeef", o.rvalid, o.rdata);
        end
    endtask

    task automatic test_byte_write();
        pins_t o, e;
        step(1'b1, 1'b1, 16'h0020, 32'h11223344, 4'hF, 1'b1, o, e);
        step(1'b1, 1'b1, 16'h0020, 32'h0000AB00, 4'b0010, 1'b1, o, e);
        checks++;
        if (o.web !== 4'b1101 || o.cs !== 1'b1) begin
            failures++; $display("FAIL byte_web got web=%b cs=%b exp web=1101 cs=1", o.web, o.cs);
        end
        step(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b1, o, e);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o.rvalid !== 1'b1 || o.rdata !== 32'h1122AB44) begin
            failures++; $display("FAIL byte_rd got rvalid=%b rdata=%h exp rvalid=1 rdata=1122ab44", o.rvalid, o.rdata);
        end
    endtask

    task automatic test_back_to_back();
        pins_t o, e;
        int    nv = 0, first = -1, last = -1;
        logic  rdy_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) step(1'b1, 1'b0, 16'(i * 4), 32'h0, 4'h0, 1'b1, o, e);
            else       step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (i < 8 && o.req_ready !== 1'b1) rdy_ok = 1'b0;
            if (o.rvalid === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
        end
        checks++;
        if (rdy_ok !== 1'b1) begin failures++; $display("FAIL b2b_ready got=0 exp=1"); end
        checks++;
        if (nv != 8 || first != 2 || last != 9) begin
            failures++; $display("FAIL b2b_timing got n=%0d first=%0d last=%0d exp n=8 first=2 last=9", nv, first, last);
        end
    endtask

    task automatic test_backpressure();
        pins_t o, e;
        int    idx = 0, acc_stalled = 0, popped = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'(idx * 4), 32'h0, 4'h0, 1'b0, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (o.req_ready === 1'b1) idx++;
        end
        acc_stalled = idx;
        checks++;
        if (acc_stalled != D) begin failures++; $display("FAIL bp_outstanding got=%0d exp=%0d", acc_stalled, D); end
        for (int i = 0; i < 30 && popped < 6; i++) begin
            step(idx < 6, 1'b0, 16'(idx * 4), 32'h0, 4'h0, 1'b1, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (idx < 6 && o.req_ready === 1'b1) idx++;
            if (o.rvalid === 1'b1) popped++;
        end
        checks++;
        if (popped != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", popped); end
    endtask

    task automatic test_random();
        pins_t o, e;
        for (int c = 0; c < 400; c++) begin
            logic        v, we, rr;
            logic [3:0]  ws;
            logic [1:0]  lo;
            int          w;
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 3) != 0);
            ws = 4'hF;
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            if (we && $urandom_range(0, 1) == 0) w = int'($urandom_range(0, 16383));
            else begin
                w = wlist[$urandom_range(0, wlist.size() - 1)];
                if (we) ws = 4'($urandom);
            end
            step(v, we, {w[13:0], lo}, $urandom, ws, rr, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        pins_t o, e;
        step(1'b1, 1'b0, 16'h0008, 32'h0, 4'h0, 1'b1, o, e);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h000C;
        RST = 1'b1;
        #1;
        o = '{bus.req_ready, bus.rvalid, bus.rdata, bus.rerr, bus.wr_err, CS, OE, WEB, A, DI};
        e = '0; e.req_ready = 1'b1; e.web = 4'hF;
        checks++;
        if (o !== e) begin failures++; $display("FAIL rst_mid got=%h exp=%h", o, e); end
        @(posedge CK); #1;
        bus.req_valid = 1'b0;
        RST = 1'b0;
        exq.delete();
        rdp_m = 1'b0;
        wre_m = 1'b0;
        cyc++;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
            checks++;
            if (o !== e || o.rvalid !== 1'b0) begin failures++; $display("FAIL rst_after cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

`ifdef SRAM_REQ_CTRL_ERR_EN
    task automatic test_err_read();
        pins_t o, e;
        step(1'b1, 1'b0, 16'h0013, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o.cs !== 1'b0) begin failures++; $display("FAIL err_rd_cs got=%b exp=0", o.cs); end
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o.rvalid !== 1'b1 || o.rerr !== 1'b1 || o.rdata !== 32'h0) begin
            failures++; $display("FAIL err_rd_rsp got rvalid=%b rerr=%b rdata=%h exp 1 1 0", o.rvalid, o.rerr, o.rdata);
        end
    endtask

    task automatic test_err_write();
        pins_t       o, e;
        logic [31:0] old;
        int          pulses = 0;
        old = ref_mem[4];
        step(1'b1, 1'b1, 16'h0011, ~old, 4'hF, 1'b1, o, e);
        checks++;
        if (o.cs !== 1'b0) begin failures++; $display("FAIL err_wr_cs got=%b exp=0", o.cs); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
            if (o.wr_err === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL err_wr_pulse got=%0d exp=1", pulses); end
        step(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b1, o, e);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, o, e);
        checks++;
        if (o.rvalid !== 1'b1 || o.rdata !== old) begin
            failures++; $display("FAIL err_wr_mem got rvalid=%b rdata=%h exp 1 %h", o.rvalid, o.rdata, old);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_prefill();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_backpressure();
        test_random();
`ifdef SRAM_REQ_CTRL_ERR_EN
        test_err_read();
        test_err_write();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request-side controller placed directly upstream of the 16K x 32 SRAM macro wrapper. Accepts word-granular read/write requests over a valid/ready port, drives the macro's CS/OE/WEB/A/DI pins in the acceptance cycle, captures DO one cycle later, and returns read data through a small response FIFO with backpressure. Sustains one request per cycle while the consumer keeps `rready` high.

## Interface
Parameters:
- `RSP_DEPTH`, default 2: response FIFO entries; legal 2..4.

Ports:
- `CK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 16: byte address; word index is `req_addr[15:2]`.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: byte enables, active-high.
- `rvalid` out 1: read response valid.
- `rready` in 1: consumer accepts response.
- `rdata` out 32: read data.
- `rerr` out 1: response error; constant 0 without the error macro.
- `wr_err` out 1: one-cycle pulse on a dropped write; constant 0 without the error macro.
- `CS`, `OE` out 1; `WEB` out 4 (active-low byte write); `A` out 14; `DI` out 32: to the SRAM wrapper.
- `DO` in 32: from the SRAM wrapper.

## Operation
- Issue: on acceptance, in the same cycle, `CS=1`, `A=req_addr[15:2]`. Write: `WEB=~req_wstrb`, `DI=req_wdata`. Read: `WEB=4'hF`.
- Idle: `CS=0`, `WEB=4'hF`, `A=0`, `DI=0`.
- Read issue sets the `rd_pend` flag for the following cycle. In that cycle `OE=1` and `DO` is pushed into the FIFO together with `rerr=0`. `OE=0` in all other cycles.
- Writes produce no response. A write with `req_wstrb=0` is still issued, with `CS=1` and `WEB=4'hF`.
- Flow control: `pop = rvalid && rready`. `req_ready = (count + rd_pend - pop) < RSP_DEPTH`. This is a combinational path from `rready` to `req_ready`, and it is intentional.
- FIFO: `rvalid = (count != 0)`. `rdata` and `rerr` come from the head entry and stay stable while `rvalid && !rready`.
- Push and pop in the same cycle: `count` is unchanged.
- Pointers wrap modulo `RSP_DEPTH`.
- Push while full cannot occur by construction. The implementation asserts this in simulation.
- Responses return strictly in request order.

## Timing
- Reset values: `req_ready=1`, `rvalid=0`, `rdata=0`, `rerr=0`, `wr_err=0`, `CS=0`, `OE=0`, `WEB=4'hF`, `A=0`, `DI=0`. Reset also clears `rd_pend`, `count` and both pointers.
- Read accepted at edge N: `DO` is valid in cycle N+1 and `rvalid` is asserted from cycle N+2. Load-to-use latency is 2 cycles.
- Throughput: 1 request per cycle with `rready` held high at `RSP_DEPTH=2`.
- When `rready` is low, at most `RSP_DEPTH` reads are outstanding, counting FIFO entries plus `rd_pend`.
- Reset asserted mid-operation: a pending read is discarded and the FIFO is flushed. No response is produced after reset deasserts.
- `req_*` inputs are don't-care when `req_valid=0`.

## Configuration
- Macro: `SRAM_REQ_CTRL_ERR_EN`.
- Defined: a request with `req_addr[1:0] != 0` is accepted but not issued, so `CS=0`.
  - Misaligned read: pushes `rdata=0`, `rerr=1` in the following cycle through the normal `rd_pend` path, so ordering and latency are unchanged.
  - Misaligned write: dropped, and `wr_err` pulses high for 1 cycle, registered, in cycle N+1.
- Undefined: `req_addr[1:0]` is ignored, `rerr` and `wr_err` are tied to 0, and no error logic is generated.

## Structure
- Package `sram_ctrl_pkg` holds:
  - `SRAM_AW=14` and `SRAM_DW=32`.
  - `SRAM_BE=4`.
  - Typedef `sram_rsp_t` as a struct of `data[31:0]` and `err`.
- Sub-module `sram_rsp_fifo`:
  - Parameterised by depth and `sram_rsp_t`.
  - Ports: push, pop, head, and `count`.
  - Asynchronous active-high reset.
- The top level holds the issue logic, `rd_pend`, `OE` control and the ready equation.

## Test plan
- Write `0x0010` with data `0xDEADBEEF` and `wstrb=4'hF`, then read `0x0010` -> in the read cycle `CS=1`, `A=14'h4`, `WEB=4'hF`; 2 cycles later `rvalid=1`, `rdata=0xDEADBEEF`.
- Byte write `wstrb=4'b0010` with data `0x0000AB00` over an existing `0x11223344` -> `WEB=4'b1101`; readback gives `0x1122AB44`.
- Back-to-back reads of words 0..7 with `rready=1` -> `req_ready` stays 1, and responses arrive on 8 consecutive cycles in order.
- Hold `rready=0` during a read burst -> `req_ready` drops once 2 reads are outstanding and `rdata` is stable; releasing `rready` drains the responses in order with no loss or duplication.
- Assert `RST` in the cycle after a read issue -> all outputs take their reset values, and no `rvalid` appears after release.
- With `SRAM_REQ_CTRL_ERR_EN` defined:
  - Read of address `0x0013` -> `CS=0`; 2 cycles later `rvalid=1`, `rerr=1`, `rdata=0`.
  - Misaligned write -> `wr_err` pulses once and memory is unchanged.
